mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory between the CPU fetch stage (IF) and the memory stage (MEM).
- Serialises the two ports' requests with fixed data priority plus anti-starvation, drives a req/ack memory handshake, returns registered read data and produces per-port stall signals for the pipeline hazard logic.
- Sits between cpu fetch/MEM logic and a shared memory model.

Parameters:
- AW, 32, byte-address width of both ports and the memory.
- STARVE_LIM, 3, consecutive lost IF arbitrations before IF is forced to win; range 1..15.
- TIMEOUT, 16, cycles mem_req may stay unacknowledged before the access is aborted; range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request, level, held until if_ready.
- if_addr  in  AW  fetch byte address.
- if_rdata  out  32  fetched word, valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for IF.
- if_stall  out  1  if_req & ~if_ready.
- dm_req  in  1  data request, level, held until dm_ready.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  AW  data byte address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data, valid while dm_ready=1.
- dm_ready  out  1  one-cycle completion pulse for the data port.
- dm_stall  out  1  dm_req & ~dm_ready.
- mem_req  out  1  memory access strobe, held until mem_ack.
- mem_we  out  1  write enable for the current access.
- mem_addr  out  AW  word-aligned address, addr[1:0] forced to 0.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, sampled when mem_ack=1.
- mem_ack  in  1  access complete; may be asserted in the first mem_req cycle.
- err  out  1  sticky timeout flag.

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset state: FSM=IDLE. All outputs 0, including mem_req, if_ready, dm_ready, both rdata buses and err. Starvation and timeout counters are 0.
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE arbitration:
  - A port whose ready output is 1 this cycle is masked, because its req still reflects the finished access.
  - If starve_cnt==STARVE_LIM and if_req is valid, grant IF.
  - Otherwise dm_req wins, then if_req.
  - On grant, register address, we and wdata (IF: we=0), then go to BUSY_IF or BUSY_DM.
- starve_cnt:
  - +1 on every grant to DM while if_req is valid and unmasked.
  - Cleared on any IF grant.
  - Saturates at STARVE_LIM.
- BUSY_x:
  - mem_req=1 with the registered mem_* outputs.
  - On mem_ack: capture mem_rdata into x_rdata (0 for stores), pulse x_ready for exactly the next cycle, return to IDLE.
  - Minimum latency, req sampled to ready: 2 cycles.
  - Back-to-back accesses to one port: at most one per 3 cycles.
- Timeout:
  - A wait counter runs while BUSY.
  - When it reaches TIMEOUT without mem_ack: drop mem_req, pulse x_ready with x_rdata=ERR_WORD (32'hDEADBEEF), set err, go to IDLE.
  - err is cleared only by reset.
- Simultaneous events:
  - mem_ack in the same cycle as the timeout: the ack wins, err is not set.
  - if_req and dm_req rising together: DM wins unless the starvation rule fires.
- Request changes: dropping x_req while BUSY_x does not abort the access. Completion still pulses x_ready, and the requester ignores it.
- Reset mid-access: everything returns immediately to the reset state; no ready pulse is issued.
- Stall outputs are combinational.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, three 16-bit saturating counters and output ports are added:
  - stat_if_grants
  - stat_dm_grants
  - stat_conflicts: cycles in IDLE with both ports requesting and unmasked.
- All counters reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, BUSY_IF, BUSY_DM), ERR_WORD constant, port-select encoding.
- Sub-module sat_counter (parameter width, inc, clr, saturating) is used for starve_cnt, the wait counter and the stats counters.

Test Plan:
- IF only, addr 0x10, memory acks in the first cycle → mem_addr=0x10, if_ready 2 cycles after req, if_rdata=mem_rdata, dm_ready never set.
- if_req and dm_req together, ack latency 1, dm_we=1, dm_addr=0x23 → DM served first with mem_addr=0x20 and mem_we=1; IF served after dm_ready.
- dm_req held high continuously with if_req high, STARVE_LIM=3 → 3 DM grants, then the 4th grant goes to IF.
- mem_ack never asserted, TIMEOUT=16 → mem_req drops after 16 busy cycles, dm_ready pulses with dm_rdata=0xDEADBEEF, err=1 and stays 1.
- rst_n low during BUSY_DM → all outputs 0 asynchronously, no ready pulse; after release a new IF request completes normally.
- MEM_ARB_STATS_EN defined, 5 simultaneous IF+DM requests → stat_conflicts≥5, and grant counters sum to the accesses completed.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_e;

    typedef enum logic {
        SEL_IF = 1'b0,
        SEL_DM = 1'b1
    } port_sel_e;

    localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch (IF) and data (DM) ports.
// Build macro MEM_ARB_STATS_EN adds 16-bit grant and conflict statistics outputs.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int STARVE_LIM = 3,
    parameter int TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_ready,
    output logic          if_stall,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [31:0]   dm_wdata,
    output logic [31:0]   dm_rdata,
    output logic          dm_ready,
    output logic          dm_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack,
    output logic          err
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_if_grants,
    output logic [15:0]   stat_dm_grants,
    output logic [15:0]   stat_conflicts
`endif
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    arb_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;
    logic          if_ready_q, if_ready_d;
    logic          dm_ready_q, dm_ready_d;
    logic          err_q, err_d;

    logic          if_vld, dm_vld, busy, starve_hit;
    logic          grant, grant_if, grant_dm;
    port_sel_e     grant_port;
    logic          done_ack, done_to;
    logic [31:0]   done_word;
    logic [3:0]    starve_cnt;
    logic [7:0]    wait_cnt;
    logic          unused_addr_lsbs;

    // A port showing ready is still holding the request that just completed.
    assign if_vld     = if_req & ~if_ready_q;
    assign dm_vld     = dm_req & ~dm_ready_q;
    assign busy       = (state_q != IDLE);
    assign starve_hit = (starve_cnt == STARVE_MAX);
    assign done_ack   = busy & mem_ack;
    assign done_to    = busy & ~mem_ack & (wait_cnt == WAIT_LAST);

    always_comb begin
        grant      = 1'b0;
        grant_port = SEL_DM;
        if (!busy) begin
            if (if_vld && (starve_hit || !dm_vld)) begin
                grant      = 1'b1;
                grant_port = SEL_IF;
            end else if (dm_vld) begin
                grant      = 1'b1;
                grant_port = SEL_DM;
            end
        end
    end

    assign grant_if = grant & (grant_port == SEL_IF);
    assign grant_dm = grant & (grant_port == SEL_DM);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_ready_d = 1'b0;
        dm_ready_d = 1'b0;
        err_d      = err_q | done_to;
        done_word  = done_ack ? (we_q ? 32'h0 : mem_rdata) : ERR_WORD;
        case (state_q)
            IDLE: begin
                if (grant_if) begin
                    state_d = BUSY_IF;
                    addr_d  = {if_addr[AW-1:2], 2'b00};
                    we_d    = 1'b0;
                    wdata_d = '0;
                end else if (grant_dm) begin
                    state_d = BUSY_DM;
                    addr_d  = {dm_addr[AW-1:2], 2'b00};
                    we_d    = dm_we;
                    wdata_d = dm_wdata;
                end
            end
            BUSY_IF: begin
                if (done_ack || done_to) begin
                    state_d    = IDLE;
                    if_ready_d = 1'b1;
                    if_rdata_d = done_word;
                end
            end
            BUSY_DM: begin
                if (done_ack || done_to) begin
                    state_d    = IDLE;
                    dm_ready_d = 1'b1;
                    dm_rdata_d = done_word;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_ready_q <= if_ready_d;
            dm_ready_q <= dm_ready_d;
            err_q      <= err_d;
        end
    end

    sat_counter #(.WIDTH(4), .MAX(STARVE_LIM)) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (grant_dm & if_vld),
        .clr   (grant_if),
        .cnt   (starve_cnt)
    );

    // Counts elapsed busy cycles; restarts for every access.
    sat_counter #(.WIDTH(8), .MAX(TIMEOUT)) u_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (busy),
        .clr   (~busy | done_ack | done_to),
        .cnt   (wait_cnt)
    );

`ifdef MEM_ARB_STATS_EN
    sat_counter #(.WIDTH(16), .MAX(65535)) u_stat_if (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (grant_if),
        .clr   (1'b0),
        .cnt   (stat_if_grants)
    );

    sat_counter #(.WIDTH(16), .MAX(65535)) u_stat_dm (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (grant_dm),
        .clr   (1'b0),
        .cnt   (stat_dm_grants)
    );

    sat_counter #(.WIDTH(16), .MAX(65535)) u_stat_conf (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~busy & if_vld & dm_vld),
        .clr   (1'b0),
        .cnt   (stat_conflicts)
    );
`endif

    assign unused_addr_lsbs = ^{if_addr[1:0], dm_addr[1:0]};

    assign mem_req   = busy;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign err       = err_q;
    assign if_stall  = if_req & ~if_ready_q;
    assign dm_stall  = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner cases, random traffic.
module tb_mem_port_arbiter;

    localparam int          AW         = 32;
    localparam int          STARVE_LIM = 3;
    localparam int          TIMEOUT    = 16;
    localparam logic [31:0] ERR_W      = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0;
    logic [31:0]   dm_wdata = '0;
    logic [31:0]   if_rdata, dm_rdata, mem_wdata;
    logic          if_ready, if_stall, dm_ready, dm_stall, mem_req, mem_we, err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata = '0;
    logic          mem_ack = 1'b0;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]   stat_if_grants, stat_dm_grants, stat_conflicts;
`endif

    mem_port_arbiter #(.AW(AW), .STARVE_LIM(STARVE_LIM), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .dm_stall  (dm_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .err       (err)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_if_grants (stat_if_grants),
        .stat_dm_grants (stat_dm_grants),
        .stat_conflicts (stat_conflicts)
`endif
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Memory responder controls and backing store
    int          ack_lat = 0;
    bit          rand_lat = 1'b0;
    bit          ack_never = 1'b0;
    logic [31:0] ref_mem [16];

    initial begin
        int req_cyc;
        int cur_lat;
        req_cyc = 0;
        cur_lat = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA5A50000 + 32'(i);
        forever begin
            @(negedge clk);
            if (!mem_req) begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                req_cyc   = 0;
            end else begin
                if (req_cyc == 0) cur_lat = rand_lat ? int'($urandom_range(0, 2)) : ack_lat;
                if (!ack_never && req_cyc >= cur_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = ref_mem[mem_addr[5:2]];
                    if (mem_we) ref_mem[mem_addr[5:2]] = mem_wdata;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
                req_cyc++;
            end
        end
    end

    // Behavioural reference: which port is being served, how long, and what it returns
    int          m_srv;
    int          m_wait;
    int          m_starve;
    bit          m_if_rdy, m_dm_rdy, m_err, m_we;
    logic [31:0] m_if_rd, m_dm_rd, m_addr, m_wdata;
    int          m_ifg, m_dmg, m_conf;

    task automatic model_reset();
        m_srv = 0; m_wait = 0; m_starve = 0;
        m_if_rdy = 0; m_dm_rdy = 0; m_err = 0; m_we = 0;
        m_if_rd = '0; m_dm_rd = '0; m_addr = '0; m_wdata = '0;
        m_ifg = 0; m_dmg = 0; m_conf = 0;
    endtask

    task automatic model_step();
        bit          nir, ndr, ifv, dmv;
        logic [31:0] v;
        if (!rst_n) begin
            model_reset();
            return;
        end
        nir = 0;
        ndr = 0;
        if (m_srv == 0) begin
            ifv = if_req && !m_if_rdy;
            dmv = dm_req && !m_dm_rdy;
            if (ifv && dmv) m_conf++;
            if (ifv && (m_starve == STARVE_LIM || !dmv)) begin
                m_srv = 1; m_starve = 0; m_ifg++;
                m_addr = {if_addr[31:2], 2'b00}; m_we = 0; m_wdata = '0; m_wait = 0;
            end else if (dmv) begin
                m_srv = 2; m_dmg++;
                if (ifv && m_starve < STARVE_LIM) m_starve++;
                m_addr = {dm_addr[31:2], 2'b00}; m_we = dm_we; m_wdata = dm_wdata; m_wait = 0;
            end
        end else begin
            m_wait++;
            if (mem_ack || m_wait == TIMEOUT) begin
                if (mem_ack) v = m_we ? 32'h0 : ref_mem[m_addr[5:2]];
                else begin
                    v = ERR_W;
                    m_err = 1;
                end
                if (m_srv == 1) begin nir = 1; m_if_rd = v; end
                else begin ndr = 1; m_dm_rd = v; end
                m_srv = 0;
            end
        end
        m_if_rdy = nir;
        m_dm_rdy = ndr;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic check_cycle();
        chk("mem_req", mem_req, m_srv != 0);
        chk("if_ready", if_ready, m_if_rdy);
        chk("dm_ready", dm_ready, m_dm_rdy);
        chk("if_stall", if_stall, if_req & ~m_if_rdy);
        chk("dm_stall", dm_stall, dm_req & ~m_dm_rdy);
        chk("err", err, m_err);
        if (m_srv != 0) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        if (m_if_rdy) chk("if_rdata", if_rdata, m_if_rd);
        if (m_dm_rdy) chk("dm_rdata", dm_rdata, m_dm_rd);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_cycle();
    endtask

    task automatic rand_drive();
        if (!if_req || m_if_rdy) begin
            if_req  = ($urandom_range(0, 3) != 0);
            if_addr = 32'($urandom_range(0, 63));
        end
        if (!dm_req || m_dm_rdy) begin
            dm_req   = ($urandom_range(0, 3) != 0);
            dm_we    = 1'($urandom_range(0, 1));
            dm_addr  = 32'($urandom_range(0, 63));
            dm_wdata = $urandom;
        end
    endtask

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_addr;
        int          exp_cyc;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int          cyc, ncomp, busy_cyc;
        bit          done;
        logic [31:0] seen_addr, got;
        logic        seen_we;
        int          comp [4];
        int          comp_exp [4];

        vecs[0] = '{0, 0, 32'h10, 32'h0,        0, 32'h10, 2, 32'hA5A50004};
        vecs[1] = '{1, 1, 32'h23, 32'h12345678, 0, 32'h20, 2, 32'h0};
        vecs[2] = '{1, 0, 32'h22, 32'h0,        2, 32'h20, 4, 32'h12345678};
        vecs[3] = '{0, 0, 32'h3F, 32'h0,        1, 32'h3C, 3, 32'hA5A5000F};
        vecs[4] = '{1, 1, 32'h04, 32'hCAFEF00D, 3, 32'h04, 5, 32'h0};
        vecs[5] = '{0, 0, 32'h07, 32'h0,        0, 32'h04, 2, 32'hCAFEF00D};
        comp_exp = '{2, 2, 2, 1};

        model_reset();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst_n = 1'b1;
        tick();

        // Single transactions from the vector table
        for (int i = 0; i < 6; i++) begin
            ack_lat = vecs[i].lat;
            if (vecs[i].is_dm) begin
                dm_req = 1; dm_we = vecs[i].we; dm_addr = vecs[i].addr; dm_wdata = vecs[i].wdata;
            end else begin
                if_req = 1; if_addr = vecs[i].addr;
            end
            cyc = 0; done = 0; seen_addr = '0; seen_we = 1'b0; got = '0;
            while (!done && cyc < 40) begin
                tick();
                cyc++;
                if (cyc == 1) begin seen_addr = mem_addr; seen_we = mem_we; end
                if (vecs[i].is_dm ? dm_ready : if_ready) begin
                    done = 1;
                    got  = vecs[i].is_dm ? dm_rdata : if_rdata;
                end
            end
            chk($sformatf("vec%0d_done", i), done, 1);
            chk($sformatf("vec%0d_addr", i), seen_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_we", i), seen_we, vecs[i].we);
            chk($sformatf("vec%0d_latency", i), cyc, vecs[i].exp_cyc);
            chk($sformatf("vec%0d_rdata", i), got, vecs[i].exp_rdata);
            if_req = 0; dm_req = 0; dm_we = 0;
            tick();
        end

        // Both ports request together: data first, fetch right after
        ack_lat = 0;
        if_req = 1; if_addr = 32'h30;
        dm_req = 1; dm_we = 1; dm_addr = 32'h23; dm_wdata = 32'h0BADF00D;
        tick();
        chk("sim_first_addr", mem_addr, 32'h20);
        chk("sim_first_we", mem_we, 1);
        tick();
        chk("sim_dm_ready", dm_ready, 1);
        chk("sim_if_waiting", if_ready, 0);
        dm_req = 0; dm_we = 0;
        tick();
        chk("sim_second_addr", mem_addr, 32'h30);
        chk("sim_second_we", mem_we, 0);
        tick();
        chk("sim_if_ready", if_ready, 1);
        chk("sim_if_rdata", if_rdata, 32'hA5A5000C);
        if_req = 0;
        tick();

        // Fetch asks only in arbitration cycles; after STARVE_LIM lost rounds it must win
        dm_req = 1; dm_we = 0; dm_addr = 32'h0; if_addr = 32'h14;
        ncomp = 0; cyc = 0;
        while (ncomp < 4 && cyc < 80) begin
            if_req = (m_srv == 0) && !m_dm_rdy;
            tick();
            cyc++;
            if (dm_ready && ncomp < 4) begin comp[ncomp] = 2; ncomp++; end
            if (if_ready && ncomp < 4) begin comp[ncomp] = 1; ncomp++; end
        end
        chk("starve_completions", ncomp, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("starve_order%0d", i), comp[i], comp_exp[i]);
        if_req = 0; dm_req = 0;
        for (int i = 0; i < 6; i++) tick();

        // Memory never acknowledges
        ack_never = 1;
        dm_req = 1; dm_we = 0; dm_addr = 32'h08;
        cyc = 0; busy_cyc = 0; done = 0;
        while (!done && cyc < 60) begin
            tick();
            cyc++;
            if (mem_req) busy_cyc++;
            if (dm_ready) done = 1;
        end
        chk("to_done", done, 1);
        chk("to_busy_cycles", busy_cyc, TIMEOUT);
        chk("to_rdata", dm_rdata, ERR_W);
        chk("to_err", err, 1);
        dm_req = 0; ack_never = 0;
        tick();
        if_req = 1; if_addr = 32'h10;
        cyc = 0; done = 0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
            if (if_ready) done = 1;
        end
        chk("post_to_done", done, 1);
        chk("post_to_err_sticky", err, 1);
        if_req = 0;
        tick();

        // Asynchronous reset in the middle of a store
        ack_lat = 5;
        dm_req = 1; dm_we = 1; dm_addr = 32'h2C; dm_wdata = 32'h55AA55AA;
        tick();
        tick();
        dm_req = 0; dm_we = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_mem_we", mem_we, 0);
        chk("arst_mem_addr", mem_addr, 32'h0);
        chk("arst_mem_wdata", mem_wdata, 32'h0);
        chk("arst_dm_ready", dm_ready, 0);
        chk("arst_if_ready", if_ready, 0);
        chk("arst_dm_rdata", dm_rdata, 32'h0);
        chk("arst_if_rdata", if_rdata, 32'h0);
        chk("arst_err", err, 0);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        ack_lat = 0;
        tick();
        if_req = 1; if_addr = 32'h2C;
        tick();
        tick();
        chk("arst_after_if_ready", if_ready, 1);
        chk("arst_after_if_rdata", if_rdata, 32'hA5A5000B);
        if_req = 0;
        tick();

        // Random traffic with random ack latency
        rand_lat = 1;
        for (int i = 0; i < 1500; i++) begin
            rand_drive();
            tick();
        end
        if_req = 0; dm_req = 0;
        for (int i = 0; i < 10; i++) tick();

`ifdef MEM_ARB_STATS_EN
        chk("stat_if_grants", stat_if_grants, 16'(m_ifg));
        chk("stat_dm_grants", stat_dm_grants, 16'(m_dmg));
        chk("stat_conflicts", stat_conflicts, 16'(m_conf));
        chk("stat_conflicts_min5", stat_conflicts >= 16'd5, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

endmodule
